// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the IO controller port; one outstanding transaction.
// Optional bus locking is enabled by defining IO_ARB_LOCK_EN.
module io_bus_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [AWIDTH-1:0]   m0_addr,
    input  logic [DWIDTH-1:0]   m0_din,
    input  logic [DWIDTH/8-1:0] m0_wbe,
    input  logic                m0_lock,
    output logic                m0_gnt,
    output logic                m0_done,
    output logic [DWIDTH-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [AWIDTH-1:0]   m1_addr,
    input  logic [DWIDTH-1:0]   m1_din,
    input  logic [DWIDTH/8-1:0] m1_wbe,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_done,
    output logic [DWIDTH-1:0]   m1_rdata,
    output logic                io_en,
    output logic [AWIDTH-1:0]   io_addr,
    output logic [DWIDTH-1:0]   io_din,
    output logic [DWIDTH/8-1:0] io_wbe,
    input  logic [DWIDTH-1:0]   io_dout
);
    localparam int BW = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t            state_r, state_n_s;
    logic              ptr_r, owner_r;
    logic              arb_en_s, win_valid_s, win_s, grant_s, lock_hold_s;
    logic              io_en_r, m0_gnt_r, m1_gnt_r, m0_done_r, m1_done_r;
    logic [AWIDTH-1:0] io_addr_r;
    logic [DWIDTH-1:0] io_din_r;
    logic [BW-1:0]     io_wbe_r;

`ifdef IO_ARB_LOCK_EN
    logic lock_r, owner_lock_s, owner_req_s;

    // Owner keeps the bus while its lock flag is set and it is still requesting with lock
    always_comb begin
        owner_lock_s = owner_r ? m1_lock : m0_lock;
        owner_req_s  = owner_r ? m1_req  : m0_req;
        lock_hold_s  = lock_r & owner_req_s & owner_lock_s;
    end

    // Lock flag: loaded in ISSUE, dropped as soon as arbitration sees the owner release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_r <= 1'b0;
        end else if (state_r == ISSUE) begin
            lock_r <= owner_lock_s;
        end else if (arb_en_s && !lock_hold_s) begin
            lock_r <= 1'b0;
        end else begin
            lock_r <= lock_r;
        end
    end
`else
    logic lock_unused_s;
    assign lock_unused_s = m0_lock | m1_lock;
    assign lock_hold_s   = 1'b0;
`endif

    // Winner selection: locked owner, else single requester, else the pointer's master
    always_comb begin
        arb_en_s    = (state_r == IDLE) || (state_r == RESP);
        win_valid_s = m0_req | m1_req;
        if (lock_hold_s) begin
            win_s = owner_r;
        end else if (m0_req && m1_req) begin
            win_s = ptr_r;
        end else if (m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        grant_s = arb_en_s & win_valid_s;
    end

    // Next-state logic
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE:    state_n_s = win_valid_s ? ISSUE : IDLE;
            ISSUE:   state_n_s = RESP;
            RESP:    state_n_s = win_valid_s ? ISSUE : IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // State, pointer and owner registers; locked grants leave the pointer alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
            owner_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            if (grant_s) begin
                owner_r <= win_s;
                if (lock_hold_s) begin
                    ptr_r <= ptr_r;
                end else begin
                    ptr_r <= ~win_s;
                end
            end else begin
                owner_r <= owner_r;
                ptr_r   <= ptr_r;
            end
        end
    end

    // IO capture registers double as the bus outputs: loaded on grant, zero otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_en_r   <= 1'b0;
            io_addr_r <= {AWIDTH{1'b0}};
            io_din_r  <= {DWIDTH{1'b0}};
            io_wbe_r  <= {BW{1'b0}};
            m0_gnt_r  <= 1'b0;
            m1_gnt_r  <= 1'b0;
            m0_done_r <= 1'b0;
            m1_done_r <= 1'b0;
        end else begin
            io_en_r   <= grant_s;
            io_addr_r <= grant_s ? (win_s ? m1_addr : m0_addr) : {AWIDTH{1'b0}};
            io_din_r  <= grant_s ? (win_s ? m1_din  : m0_din)  : {DWIDTH{1'b0}};
            io_wbe_r  <= grant_s ? (win_s ? m1_wbe  : m0_wbe)  : {BW{1'b0}};
            m0_gnt_r  <= grant_s & ~win_s;
            m1_gnt_r  <= grant_s &  win_s;
            m0_done_r <= (state_r == ISSUE) & ~owner_r;
            m1_done_r <= (state_r == ISSUE) &  owner_r;
        end
    end

    assign io_en    = io_en_r;
    assign io_addr  = io_addr_r;
    assign io_din   = io_din_r;
    assign io_wbe   = io_wbe_r;
    assign m0_gnt   = m0_gnt_r;
    assign m1_gnt   = m1_gnt_r;
    assign m0_done  = m0_done_r;
    assign m1_done  = m1_done_r;
    // Read data passes through in the RESP cycle, since io_dout arrives one cycle after io_en
    assign m0_rdata = m0_done_r ? io_dout : {DWIDTH{1'b0}};
    assign m1_rdata = m1_done_r ? io_dout : {DWIDTH{1'b0}};
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: stimulus queues expected issue/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_io_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m0_gnt, m0_done;
    logic [9:0]  m0_addr;
    logic [31:0] m0_din, m0_rdata;
    logic [3:0]  m0_wbe;
    logic        m1_req, m1_lock, m1_gnt, m1_done;
    logic [9:0]  m1_addr;
    logic [31:0] m1_din, m1_rdata;
    logic [3:0]  m1_wbe;
    logic        io_en;
    logic [9:0]  io_addr;
    logic [31:0] io_din, io_dout;
    logic [3:0]  io_wbe;
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] cyc;
        bit          owner;
        logic [9:0]  addr;
        logic [31:0] din;
        logic [3:0]  wbe;
    } iss_t;

    typedef struct {
        logic [31:0] cyc;
        bit          owner;
        logic [31:0] rdata;
    } done_t;

    iss_t  iss_q[$];
    done_t done_q[$];

    io_bus_arbiter #(.DWIDTH(32), .AWIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din), .m0_wbe(m0_wbe),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din), .m1_wbe(m1_wbe),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .io_en(io_en), .io_addr(io_addr), .io_din(io_din), .io_wbe(io_wbe),
        .io_dout(io_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // IO controller stand-in: read data is a known function of the cycle number
    assign io_dout = 32'hA500_0000 ^ cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect an ISSUE at cycle icyc and the matching done one cycle later
    task automatic push_txn(input bit owner, input logic [31:0] icyc, input logic [9:0] addr,
                            input logic [31:0] din, input logic [3:0] wbe);
        iss_t  ie;
        done_t de;
        ie.cyc = icyc; ie.owner = owner; ie.addr = addr; ie.din = din; ie.wbe = wbe;
        de.cyc = icyc + 32'd1; de.owner = owner; de.rdata = 32'hA500_0000 ^ (icyc + 32'd1);
        iss_q.push_back(ie);
        done_q.push_back(de);
    endtask

    // Monitor: pop and compare whenever the DUT issues or completes; otherwise outputs must be idle
    always @(negedge clk) begin
        iss_t  ie;
        done_t de;
        if (io_en || m0_gnt || m1_gnt) begin
            if (iss_q.size() == 0) begin
                check("unexpected_issue", {m1_gnt, m0_gnt, io_en}, 3'b000);
            end else begin
                ie = iss_q.pop_front();
                check("issue_cycle", cyc, ie.cyc);
                check("issue_io_en", io_en, 1'b1);
                check("issue_gnt", {m1_gnt, m0_gnt}, ie.owner ? 2'b10 : 2'b01);
                check("issue_bus", {io_addr, io_din, io_wbe}, {ie.addr, ie.din, ie.wbe});
            end
        end else begin
            check("idle_bus", {io_addr, io_din, io_wbe}, 46'd0);
        end
        if (m0_done || m1_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", {m1_done, m0_done}, 2'b00);
            end else begin
                de = done_q.pop_front();
                check("done_cycle", cyc, de.cyc);
                check("done_who", {m1_done, m0_done}, de.owner ? 2'b10 : 2'b01);
                check("done_rdata", de.owner ? m1_rdata : m0_rdata, de.rdata);
                check("done_other_rdata", de.owner ? m0_rdata : m1_rdata, 32'd0);
            end
        end else begin
            check("idle_rdata", {m1_rdata, m0_rdata}, 64'd0);
        end
    end

    initial begin
        logic [31:0] c;
        rst = 1'b0;
        m0_req = 1'b0; m0_lock = 1'b0; m0_addr = 10'h010; m0_din = 32'd0; m0_wbe = 4'h0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_addr = 10'h014; m1_din = 32'd0; m1_wbe = 4'h0;

        // Reset held with both masters requesting: everything stays quiet
        tick();
        m0_req = 1'b1; m1_req = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {io_en, m0_gnt, m1_gnt, m0_done, m1_done, io_addr, io_din, io_wbe},
              51'd0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);

        // Release: m0 first (pointer at 0), then m1 back-to-back from RESP
        c = cyc;
        rst = 1'b1;
        push_txn(1'b0, c + 32'd1, 10'h010, 32'd0, 4'h0);
        push_txn(1'b1, c + 32'd3, 10'h014, 32'd0, 4'h0);
        tick(); m0_req = 1'b0;
        tick(); tick(); m1_req = 1'b0;
        repeat (2) tick();

        // Single m0 write
        c = cyc;
        m0_addr = 10'h008; m0_din = 32'h5; m0_wbe = 4'hF; m0_req = 1'b1;
        push_txn(1'b0, c + 32'd1, 10'h008, 32'h5, 4'hF);
        tick(); m0_req = 1'b0;
        repeat (2) tick();

        // Single m1 read puts the pointer back on m0
        c = cyc;
        m1_addr = 10'h030; m1_din = 32'd0; m1_wbe = 4'h0; m1_req = 1'b1;
        push_txn(1'b1, c + 32'd1, 10'h030, 32'd0, 4'h0);
        tick(); m1_req = 1'b0;
        repeat (2) tick();

        // Both requesting continuously: 8 alternating grants, one every 2 cycles
        m0_addr = 10'h100; m0_din = 32'h11; m0_wbe = 4'h0;
        m1_addr = 10'h200; m1_din = 32'h22; m1_wbe = 4'hF;
        c = cyc;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_txn(1'b0, c + 32'd1 + 32'(2 * k), 10'h100, 32'h11, 4'h0);
            else            push_txn(1'b1, c + 32'd1 + 32'(2 * k), 10'h200, 32'h22, 4'hF);
        end
        repeat (15) tick();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        // Reset during ISSUE: io_en drops at once, no done, pending m1 granted after release
        m0_addr = 10'h040; m0_din = 32'd0; m0_wbe = 4'h0; m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        m1_addr = 10'h044; m1_din = 32'd0; m1_wbe = 4'h0; m1_req = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_async_io_en", io_en, 1'b0);
        check("rst_async_gnt", {m0_gnt, m1_gnt}, 2'b00);
        repeat (2) tick();
        c = cyc;
        rst = 1'b1;
        push_txn(1'b1, c + 32'd1, 10'h044, 32'd0, 4'h0);
        tick(); m1_req = 1'b0;
        repeat (2) tick();

`ifdef IO_ARB_LOCK_EN
        // m1 locks for 3 transactions while m0 waits; m0 follows once lock drops
        c = cyc;
        m1_addr = 10'h050; m1_din = 32'h33; m1_wbe = 4'hF; m1_req = 1'b1; m1_lock = 1'b1;
        push_txn(1'b1, c + 32'd1, 10'h050, 32'h33, 4'hF);
        tick();
        m0_addr = 10'h060; m0_din = 32'd0; m0_wbe = 4'h0; m0_req = 1'b1;
        push_txn(1'b1, c + 32'd3, 10'h050, 32'h33, 4'hF);
        tick(); tick();
        push_txn(1'b1, c + 32'd5, 10'h050, 32'h33, 4'hF);
        tick(); tick();
        m1_req = 1'b0; m1_lock = 1'b0;
        push_txn(1'b0, c + 32'd7, 10'h060, 32'd0, 4'h0);
        tick(); tick();
        m0_req = 1'b0;
        repeat (2) tick();
`endif

        repeat (3) tick();
        check("iss_queue_drained", 64'(iss_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
